proc_control_fsm: RTL and testbench
===================================

Name: proc_control_fsm

Overview:
- Instruction-sequencing control unit for the 16-bit bus processor.
- It fetches a 9-bit instruction from DIN into an internal IR, then steps through time states T0–T3.
- In each step it drives the bus-multiplexer selects (one-hot register select, G select, DIN select) and the load enables for the R0–R7, A and G registers.
- It is the initiator end of the bus-mux select interface: it generates the selects that the multiplexer consumes.

Parameters:
- DATA_W, 16: width of DIN.
- OPC_W, 3: opcode field width (IR[8:6]).
- REG_W, 3: register-index field width; NREG = 2**REG_W = 8.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; clears state and IR.
- Run  input  1  start request; sampled only in T0.
- DIN  input  DATA_W  instruction/data input; IR loads DIN[8:0].
- IRin  output  1  IR load enable (informational; IR is internal).
- Rout  output  8  one-hot bus select; bit 7 = R0 … bit 0 = R7.
- Gout  output  1  select G onto bus.
- DINout  output  1  select DIN onto bus.
- Rin  output  8  register load enables; bit 7 = R0 … bit 0 = R7.
- Ain  output  1  A load enable.
- Gin  output  1  G load enable.
- AddSub  output  1  ALU op: 0 = add, 1 = sub.
- Done  output  1  high during the final step of an instruction.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high and has priority over everything: at the next edge state = T0, IR = 0.
- Output timing: all outputs are combinational from (state, IR, Run).
  - In T0, every output except IRin is 0.
  - Rout, Gout and DINout are mutually exclusive; at most one bit of the three is set in any state.
- IR fields: op = IR[8:6], X = IR[5:3], Y = IR[2:0]. Index i maps to bit (7−i) of Rout/Rin.
- T0: IRin = Run. If Run, IR <= DIN[8:0] and go to T1; otherwise stay in T0. Run is ignored in T1–T3.
- mv (000) Rx,Ry:
  - T1: Rout[Y], Rin[X], Done. Then T0.
- mvi (001) Rx,#D:
  - T1: DINout, Rin[X], Done; the immediate is DIN in that cycle. Then T0.
- add (010) / sub (011):
  - T1: Rout[X], Ain.
  - T2: Rout[Y], Gin, AddSub = op[0].
  - T3: Gout, Rin[X], Done. Then T0.
  - X = Y is legal; it yields 2·Rx or 0.
- Opcodes 100–111: behaviour depends on CTRL_ILLEGAL_FLAG_EN.
- Latency: mv/mvi take 2 cycles including fetch; add/sub take 4.
- Back-to-back: with Run held high, the next fetch occurs in the T0 cycle immediately after Done.
- Reset mid-instruction: the FSM aborts with no Done and no further Rin. Registers already loaded keep their values.
- AddSub is 0 in every state except T2 of sub.

Optional Feature:
- Macro: CTRL_ILLEGAL_FLAG_EN.
- Defined:
  - Adds output Illegal (1 bit).
  - For opcodes 100–111, T1 drives Illegal = 1 and Done = 1 with all enables 0, then goes to T0.
  - Illegal is 0 in all other states and after reset.
- Undefined:
  - Port absent.
  - Opcodes 100–111 behave as a NOP: T1 drives Done = 1 only, then T0.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_MV = 3'b000, OP_MVI = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011;
  - the state typedef (T0..T3, 2 bits);
  - NREG.
- One sub-module: reg_dec3to8, a 3-bit to one-hot decoder (index 0 → bit 7). It is instantiated twice, for X and Y.

Test Plan:
- Reset: assert Reset for 2 cycles with Run = 1 → state T0; Rout = 0, Rin = 0, Done = 0; IRin = 1 only once Reset is low.
- mv R2,R5 (DIN = 9'b000_010_101) with Run pulsed → T1: Rout = 8'b00000100, Rin = 8'b00100000, Done = 1; next cycle T0.
- mvi R7,#0x1234 → T1: DINout = 1, Rin = 8'b00000001, Done = 1, Rout = 0.
- sub R0,R1 → T1: Rout = 8'h80, Ain = 1; T2: Rout = 8'h40, Gin = 1, AddSub = 1; T3: Gout = 1, Rin = 8'h80, Done = 1.
- Run held high through two add instructions → second fetch in the cycle after the first Done; Done pulses are 4 cycles apart.
- Reset asserted in T2 of add → next cycle T0, no Done, no Rin. With CTRL_ILLEGAL_FLAG_EN, opcode 111 → T1: Illegal = 1, Done = 1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the bus-processor control unit: opcodes, time-state
// encoding and register count.
package proc_pkg;

  // Number of general-purpose registers (R0..R7), 2**3
  localparam int unsigned NREG = 8;

  // Time-state encoding; kept as plain 2-bit constants for legacy tooling
  typedef logic [1:0] state_t;
  localparam state_t T0 = 2'd0;
  localparam state_t T1 = 2'd1;
  localparam state_t T2 = 2'd2;
  localparam state_t T3 = 2'd3;

  // Opcode field values (IR[8:6])
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // True for opcodes that need the A/G accumulate path (T2/T3)
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/reg_dec3to8.sv
// 3-bit register index to one-hot select. Index 0 (R0) maps to bit 7 so the
// select vectors read R0..R7 from MSB to LSB.
module reg_dec3to8
  import proc_pkg::*;
(
  input  logic [2:0]      idx_i,
  output logic [NREG-1:0] onehot_o
);

  // Reverse-ordered one-hot decode
  always_comb begin
    onehot_o = '0;
    unique case (idx_i)
      3'd0: onehot_o = 8'b1000_0000;
      3'd1: onehot_o = 8'b0100_0000;
      3'd2: onehot_o = 8'b0010_0000;
      3'd3: onehot_o = 8'b0001_0000;
      3'd4: onehot_o = 8'b0000_1000;
      3'd5: onehot_o = 8'b0000_0100;
      3'd6: onehot_o = 8'b0000_0010;
      3'd7: onehot_o = 8'b0000_0001;
      default: onehot_o = '0;
    endcase
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Instruction-sequencing control unit for the 16-bit bus processor.
// Fetches a 9-bit instruction into IR in T0, then walks T1..T3 driving the
// bus-mux selects and register load enables.
// Optional: define CTRL_ILLEGAL_FLAG_EN to add the Illegal output, which flags
// opcodes 100-111 in T1; otherwise those opcodes execute as a NOP.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OPC_W  = 3,
  parameter int unsigned REG_W  = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              IRin,
  output logic [NREG-1:0]   Rout,
  output logic              Gout,
  output logic              DINout,
  output logic [NREG-1:0]   Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done
`ifdef CTRL_ILLEGAL_FLAG_EN
  ,
  output logic              Illegal
`endif
);

  localparam int unsigned IR_W = OPC_W + 2 * REG_W;

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q;
  logic              ir_load;
  logic [OPC_W-1:0]  ir_op;
  logic [REG_W-1:0]  ir_x, ir_y;
  logic [NREG-1:0]   x_sel, y_sel;

  // Upper DIN bits carry data only; the control unit never looks at them
  logic unused_din;
  assign unused_din = ^DIN[DATA_W-1:IR_W];

  assign ir_op = ir_q[IR_W-1 -: OPC_W];
  assign ir_x  = ir_q[2*REG_W-1 -: REG_W];
  assign ir_y  = ir_q[REG_W-1:0];

  // Run is only honoured in T0
  assign ir_load = (state_q == T0) && Run;

  reg_dec3to8 u_dec_x (
    .idx_i    (ir_x),
    .onehot_o (x_sel)
  );

  reg_dec3to8 u_dec_y (
    .idx_i    (ir_y),
    .onehot_o (y_sel)
  );

  // State and instruction register; Reset has priority over fetch
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) begin
        ir_q <= DIN[IR_W-1:0];
      end
    end
  end

  // Next-state: only add/sub continue past T1
  always_comb begin
    state_d = T0;
    unique case (state_q)
      T0:      state_d = Run ? T1 : T0;
      T1:      state_d = is_alu_op(ir_op) ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // Per-step selects and enables
  always_comb begin
    IRin   = 1'b0;
    Rout   = '0;
    Gout   = 1'b0;
    DINout = 1'b0;
    Rin    = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
`ifdef CTRL_ILLEGAL_FLAG_EN
    Illegal = 1'b0;
`endif
    unique case (state_q)
      T0: begin
        // Masked during Reset: the fetch would be discarded anyway
        IRin = Run & ~Reset;
      end
      T1: begin
        unique case (ir_op)
          OP_MV: begin
            Rout = y_sel;
            Rin  = x_sel;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = x_sel;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout = x_sel;
            Ain  = 1'b1;
          end
          default: begin
            Done = 1'b1;
`ifdef CTRL_ILLEGAL_FLAG_EN
            Illegal = 1'b1;
`endif
          end
        endcase
      end
      T2: begin
        Rout   = y_sel;
        Gin    = 1'b1;
        AddSub = ir_op[0];
      end
      T3: begin
        Gout = 1'b1;
        Rin  = x_sel;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm. Each cycle's expected output vector is
// queued as the stimulus is applied and checked on the falling edge.
module tb_proc_control_fsm;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic        IRin, Gout, DINout, Ain, Gin, AddSub, Done;
  logic [7:0]  Rout, Rin;
  logic        Illegal;

`ifdef CTRL_ILLEGAL_FLAG_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
  assign Illegal = 1'b0;
`endif

  proc_control_fsm dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .IRin   (IRin),
    .Rout   (Rout),
    .Gout   (Gout),
    .DINout (DINout),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done)
`ifdef CTRL_ILLEGAL_FLAG_EN
    ,
    .Illegal(Illegal)
`endif
  );

  always #5 Clock = ~Clock;

  logic [23:0] exp_q[$];
  string       tag_q[$];
  int          passed = 0;
  int          total  = 0;

  function automatic logic [23:0] ev(input logic irin, input logic [7:0] rout, input logic gout,
                                     input logic dinout, input logic [7:0] rin, input logic ain,
                                     input logic gin, input logic addsub, input logic done,
                                     input logic ill);
    return {ill, irin, rout, gout, dinout, rin, ain, gin, addsub, done};
  endfunction

  task automatic check();
    logic [23:0] obs, e;
    string t;
    obs = {Illegal, IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s: observed %h expected %h", t, obs, e);
  endtask

  // Apply one cycle of stimulus, queue its expectation, check mid-cycle
  task automatic cyc(input string tag, input logic rst, input logic run,
                     input logic [15:0] din, input logic [23:0] e);
    Reset = rst;
    Run   = run;
    DIN   = din;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge Clock);
    check();
    @(posedge Clock);
    #1;
  endtask

  localparam logic [23:0] ZERO = 24'h0;

  initial begin
    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 16'h0;
    @(posedge Clock);
    #1;
    // Reset held with Run high: IRin stays low
    cyc("reset_hold", 1'b1, 1'b1, 16'h0, ZERO);
    // mv R2,R5
    cyc("mv_fetch", 1'b0, 1'b1, 16'b000_010_101, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("mv_t1",    1'b0, 1'b0, 16'h0,
        ev(0, 8'b0000_0100, 0, 0, 8'b0010_0000, 0, 0, 0, 1, 0));
    cyc("mv_back_t0", 1'b0, 1'b0, 16'h0, ZERO);
    // mvi R7,#0x1234
    cyc("mvi_fetch", 1'b0, 1'b1, 16'b001_111_000, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("mvi_t1",    1'b0, 1'b0, 16'h1234, ev(0, 8'h00, 0, 1, 8'h01, 0, 0, 0, 1, 0));
    cyc("idle_t0",   1'b0, 1'b0, 16'h0, ZERO);
    // sub R0,R1; Run left high in T1/T2 must be ignored
    cyc("sub_fetch", 1'b0, 1'b1, 16'b011_000_001, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("sub_t1",    1'b0, 1'b1, 16'h0, ev(0, 8'h80, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    cyc("sub_t2",    1'b0, 1'b1, 16'h0, ev(0, 8'h40, 0, 0, 8'h00, 0, 1, 1, 0, 0));
    cyc("sub_t3",    1'b0, 1'b0, 16'h0, ev(0, 8'h00, 1, 0, 8'h80, 0, 0, 0, 1, 0));
    cyc("sub_done_t0", 1'b0, 1'b0, 16'h0, ZERO);
    // Back-to-back: add R3,R3 then add R1,R2 with Run held high
    cyc("add1_fetch", 1'b0, 1'b1, 16'b010_011_011, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("add1_t1",    1'b0, 1'b1, 16'hFFFF, ev(0, 8'h10, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    cyc("add1_t2",    1'b0, 1'b1, 16'hFFFF, ev(0, 8'h10, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    cyc("add1_t3",    1'b0, 1'b1, 16'hFFFF, ev(0, 8'h00, 1, 0, 8'h10, 0, 0, 0, 1, 0));
    cyc("add2_fetch", 1'b0, 1'b1, 16'b010_001_010, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("add2_t1",    1'b0, 1'b1, 16'h0, ev(0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    cyc("add2_t2",    1'b0, 1'b1, 16'h0, ev(0, 8'h20, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    cyc("add2_t3",    1'b0, 1'b0, 16'h0, ev(0, 8'h00, 1, 0, 8'h40, 0, 0, 0, 1, 0));
    cyc("add2_done_t0", 1'b0, 1'b0, 16'h0, ZERO);
    // Reset during T2 of add R0,R0 aborts without Done/Rin
    cyc("abort_fetch", 1'b0, 1'b1, 16'b010_000_000, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("abort_t1",    1'b0, 1'b0, 16'h0, ev(0, 8'h80, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    cyc("abort_t2",    1'b1, 1'b0, 16'h0, ev(0, 8'h80, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    cyc("abort_t0",    1'b0, 1'b0, 16'h0, ZERO);
    cyc("abort_idle",  1'b0, 1'b0, 16'h0, ZERO);
    // Opcode 111: flagged or NOP depending on build
    cyc("op7_fetch", 1'b0, 1'b1, 16'b111_000_000, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("op7_t1",    1'b0, 1'b0, 16'h0, ev(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, ILL));
    cyc("op7_t0",    1'b0, 1'b0, 16'h0, ZERO);
    // mv R6,R6 right after: IR must have reloaded
    cyc("mv66_fetch", 1'b0, 1'b1, 16'b000_110_110, ev(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    cyc("mv66_t1",    1'b0, 1'b0, 16'h0, ev(0, 8'h02, 0, 0, 8'h02, 0, 0, 0, 1, 0));
    cyc("final_t0",   1'b0, 1'b0, 16'h0, ZERO);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
